// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel push-button synchroniser, debouncer and press/release/long-press strobes
module button_conditioner #(
    parameter int N               = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] long_pulse,
    output logic [N-1:0] held_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_LONG     = 2'd2
    } state_t;

    // Internal convention: 1 = pressed, regardless of pin polarity.
    logic [N-1:0] btn_int;
    assign btn_int = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          sync1_q, sync1_d;
        logic          sync2_q, sync2_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          long_q, long_d;
        logic          held_q, held_d;
        logic [DW-1:0] db_cnt_q, db_cnt_d;
        logic [LW-1:0] long_cnt_q, long_cnt_d;
        state_t        state_q, state_d;
        logic          accept;

        always_comb begin
            sync1_d  = btn_int[i];
            sync2_d  = sync1_q;
            accept   = 1'b0;
            level_d  = level_q;
            db_cnt_d = '0;
            // Counter only survives while the input keeps disagreeing with the level.
            if (sync2_q != level_q) begin
                if (db_cnt_q == DB_MAX) begin
                    accept  = 1'b1;
                    level_d = ~level_q;
                end else begin
                    db_cnt_d = db_cnt_q + DW'(1);
                end
            end

            state_d    = state_q;
            long_cnt_d = long_cnt_q;
            press_d    = 1'b0;
            rel_d      = 1'b0;
            long_d     = 1'b0;
            held_d     = held_q;
            case (state_q)
                ST_RELEASED: begin
                    long_cnt_d = '0;
                    if (accept && !level_q) begin
                        state_d = ST_PRESSED;
                        press_d = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // A release landing on the long threshold wins: no long strobe.
                    if (accept && level_q) begin
                        state_d    = ST_RELEASED;
                        rel_d      = 1'b1;
                        long_cnt_d = '0;
                    end else if (long_cnt_q == LONG_MAX) begin
                        state_d = ST_LONG;
                        long_d  = 1'b1;
                        held_d  = 1'b1;
                    end else begin
                        long_cnt_d = long_cnt_q + LW'(1);
                    end
                end
                ST_LONG: begin
                    if (accept && level_q) begin
                        state_d = ST_RELEASED;
                        rel_d   = 1'b1;
                        held_d  = 1'b0;
                    end
                end
                default: begin
                    state_d    = ST_RELEASED;
                    long_cnt_d = '0;
                    held_d     = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                rel_q      <= 1'b0;
                long_q     <= 1'b0;
                held_q     <= 1'b0;
                db_cnt_q   <= '0;
                long_cnt_q <= '0;
                state_q    <= ST_RELEASED;
            end else begin
                sync1_q    <= sync1_d;
                sync2_q    <= sync2_d;
                level_q    <= level_d;
                press_q    <= press_d;
                rel_q      <= rel_d;
                long_q     <= long_d;
                held_q     <= held_d;
                db_cnt_q   <= db_cnt_d;
                long_cnt_q <= long_cnt_d;
                state_q    <= state_d;
            end
        end

        assign btn_level[i]     = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = rel_q;
        assign long_pulse[i]    = long_q;
        assign held_long[i]     = held_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;
    localparam int D = 4;
    localparam int L = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] raw = 2'b11;
    logic [1:0] raw_ah = 2'b00;
    logic [1:0] lvl, prs, rel, lng, hld;
    logic [1:0] lvl_ah, prs_ah, rel_ah, lng_ah, hld_ah;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    button_conditioner #(.N(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw),
        .btn_level(lvl), .press_pulse(prs), .release_pulse(rel),
        .long_pulse(lng), .held_long(hld)
    );

    button_conditioner #(.N(2), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut_ah (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_ah),
        .btn_level(lvl_ah), .press_pulse(prs_ah), .release_pulse(rel_ah),
        .long_pulse(lng_ah), .held_long(hld_ah)
    );

    typedef struct {
        logic [1:0] raw;
        logic [9:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [9:0] outs();
        return {lvl, prs, rel, lng, hld};
    endfunction

    function automatic logic [9:0] pack(input logic [1:0] l, input logic [1:0] p,
                                        input logic [1:0] r, input logic [1:0] g,
                                        input logic [1:0] h);
        return {l, p, r, g, h};
    endfunction

    function automatic vec_t mk(input logic [1:0] r, input logic [1:0] l,
                                input logic [1:0] p, input logic [1:0] q);
        vec_t v;
        v.raw = r;
        v.exp = pack(l, p, q, 2'b00, 2'b00);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a level flips once the last D synchronised samples all
    // disagree with it and at least D edges have passed since the previous flip.
    int   hist[2][$];
    int   last_flip[2];
    int   press_e[2];
    logic m_lvl[2];
    logic m_held[2];
    logic m_fired[2];

    function automatic int samp(input int c, input int k);
        if (k >= 1) return hist[c][k-1];
        return 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            hist[c].delete();
            last_flip[c] = -1000;
            press_e[c]   = -1000;
            m_lvl[c]     = 1'b0;
            m_held[c]    = 1'b0;
            m_fired[c]   = 1'b0;
        end
    endtask

    task automatic model_edge(input int e, input logic [1:0] r, output logic [9:0] exp);
        logic [1:0] l, p, q, g, h;
        for (int c = 0; c < 2; c++) begin
            bit all_diff;
            p[c] = 1'b0;
            q[c] = 1'b0;
            g[c] = 1'b0;
            hist[c].push_back(r[c] ? 0 : 1);
            if (e - last_flip[c] >= D) begin
                all_diff = 1'b1;
                for (int k = e - D - 1; k <= e - 2; k++)
                    if (samp(c, k) == int'(m_lvl[c])) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl[c]     = ~m_lvl[c];
                    last_flip[c] = e;
                    if (m_lvl[c]) begin
                        p[c]       = 1'b1;
                        press_e[c] = e;
                        m_fired[c] = 1'b0;
                    end else begin
                        q[c]      = 1'b1;
                        m_held[c] = 1'b0;
                    end
                end
            end
            if (m_lvl[c] && !m_fired[c] && (e - press_e[c] == L)) begin
                g[c]       = 1'b1;
                m_held[c]  = 1'b1;
                m_fired[c] = 1'b1;
            end
            l[c] = m_lvl[c];
            h[c] = m_held[c];
        end
        exp = pack(l, p, q, g, h);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] e;
        int np, nr, nl;
        int hold_left[2];
        logic [1:0] r;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs(), 10'd0);
        check("reset_outs_ah", {lvl_ah, prs_ah, rel_ah, lng_ah, hld_ah}, 10'd0);
        rst_n = 1'b1;

        // Both pins released for 50 cycles
        raw = 2'b11;
        for (int k = 1; k <= 50; k++) begin
            tick();
            check($sformatf("idle_%0d", k), outs(), 10'd0);
        end

        // Table: short press/release on ch0, then sub-debounce bouncing
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00));
        for (int k = 1; k <= 5; k++) tbl.push_back(mk(2'b10, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b10, 2'b01, 2'b01, 2'b00));
        tbl.push_back(mk(2'b10, 2'b01, 2'b00, 2'b00));
        for (int k = 1; k <= 5; k++) tbl.push_back(mk(2'b11, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00));
        for (int k = 0; k < 20; k++)
            tbl.push_back(mk(((k / 2) % 2 == 0) ? 2'b10 : 2'b11, 2'b00, 2'b00, 2'b00));
        for (int k = 0; k < 6; k++) tbl.push_back(mk(2'b11, 2'b00, 2'b00, 2'b00));
        for (int i = 0; i < tbl.size(); i++) begin
            raw = tbl[i].raw;
            tick();
            check($sformatf("tbl_%0d", i), outs(), tbl[i].exp);
        end

        // Long press on ch0 then release
        raw = 2'b10;
        for (int k = 1; k <= 40; k++) begin
            tick();
            e = pack({1'b0, k >= 6}, {1'b0, k == 6}, 2'b00, {1'b0, k == 26}, {1'b0, k >= 26});
            check($sformatf("long_hold_%0d", k), outs(), e);
        end
        raw = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e = pack({1'b0, k < 6}, 2'b00, {1'b0, k == 6}, 2'b00, {1'b0, k < 6});
            check($sformatf("long_release_%0d", k), outs(), e);
        end

        // Medium press (10 cycles): press and release, never long
        np = 0; nr = 0; nl = 0;
        raw = 2'b10;
        for (int k = 1; k <= 10; k++) begin
            tick();
            np += prs[0]; nr += rel[0]; nl += lng[0];
        end
        raw = 2'b11;
        for (int k = 1; k <= 30; k++) begin
            tick();
            np += prs[0]; nr += rel[0]; nl += lng[0];
        end
        check("med_press_count", np, 1);
        check("med_release_count", nr, 1);
        check("med_long_count", nl, 0);

        // Reset while ch1 is in LONG with the pin still held
        raw = 2'b01;
        repeat (27) tick();
        check("ch1_held_before_reset", hld, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", outs(), 10'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("in_reset_outs", outs(), 10'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            e = pack({k >= 6, 1'b0}, {k == 6, 1'b0}, 2'b00, {k == 26, 1'b0}, {k >= 26, 1'b0});
            check($sformatf("post_reset_%0d", k), outs(), e);
        end
        raw = 2'b11;
        repeat (10) tick();
        check("post_reset_released", outs(), 10'd0);

        // Active-high instance: both pins pressed in the same cycle
        raw_ah = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("ah_press_%0d", k), prs_ah, (k == 6) ? 2'b11 : 2'b00);
            check($sformatf("ah_level_%0d", k), lvl_ah, (k >= 6) ? 2'b11 : 2'b00);
        end
        raw_ah = 2'b00;

        // Randomised holds against the reference model
        rst_n = 1'b0;
        raw = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        hold_left[0] = 0;
        hold_left[1] = 0;
        r = 2'b11;
        for (int cyc = 1; cyc <= 1500; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                if (hold_left[c] == 0) begin
                    r[c] = $urandom_range(0, 1) == 1;
                    hold_left[c] = $urandom_range(1, 40);
                end
                hold_left[c]--;
            end
            raw = r;
            tick();
            model_edge(cyc, raw, e);
            check($sformatf("rand_%0d", cyc), outs(), e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
